// File: rtl/uart_tx_buffered.sv
// Byte-wide FIFO feeding an 8N1 serializer; the serializer pops the head byte at
// the start of every frame and chains frames back-to-back while data is queued.
module uart_tx_buffered #(
  parameter int                      TIMER_BITS      = 32,
  parameter logic [TIMER_BITS-1:0]   CLOCKS_PER_BAUD = TIMER_BITS'(868),
  parameter int                      DEPTH_LOG2      = 4
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_wr,
  input  logic [7:0]            i_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_busy,
  output logic                  o_tx
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [TIMER_BITS-1:0] CPB_M1   = CLOCKS_PER_BAUD - 1'b1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  push, pop;
  logic [7:0]            head;

  logic [1:0]            state;
  logic [TIMER_BITS-1:0] timer;
  logic                  timer_zero;
  logic [2:0]            bit_idx;
  logic [7:0]            shreg;

  assign head       = mem[rd_ptr];
  assign timer_zero = (timer == '0);
  // Occupancy flags are registered, so push/pop decisions use the count as seen at this edge.
  assign push = i_wr && !o_full;
  assign pop  = !o_empty && ((state == S_IDLE) || (state == S_STOP && timer_zero));

  always_comb begin
    count_nxt = o_count;
    case ({push, pop})
      2'b10:   count_nxt = o_count + 1'b1;
      2'b01:   count_nxt = o_count - 1'b1;
      default: count_nxt = o_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_empty    <= 1'b1;
      o_full     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (push)           wr_ptr     <= wr_ptr + 1'b1;
      if (pop)            rd_ptr     <= rd_ptr + 1'b1;
      if (i_wr && o_full) o_overflow <= 1'b1;
      o_count <= count_nxt;
      o_empty <= (count_nxt == '0);
      o_full  <= (count_nxt == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      o_tx    <= 1'b1;
      o_busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shreg  <= head;
            state  <= S_START;
            timer  <= CPB_M1;
            o_tx   <= 1'b0;
            o_busy <= 1'b1;
          end
        end
        S_START: begin
          if (timer_zero) begin
            state   <= S_DATA;
            timer   <= CPB_M1;
            bit_idx <= '0;
            o_tx    <= shreg[0];
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_DATA: begin
          if (timer_zero) begin
            timer <= CPB_M1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              o_tx  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              o_tx    <= shreg[1];
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_STOP: begin
          // Chain straight into the next start bit when more data is waiting.
          if (timer_zero) begin
            if (pop) begin
              shreg <= head;
              state <= S_START;
              timer <= CPB_M1;
              o_tx  <= 1'b0;
            end else begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed + randomized bench for uart_tx_buffered with a line-level 8N1 decoder.
module tb_uart_tx_buffered;
  localparam int CPB = 4;
  localparam int DL2 = 4;

  logic           clk = 1'b0;
  logic           i_reset = 1'b0;
  logic           i_wr = 1'b0;
  logic [7:0]     i_data = 8'h00;
  logic           o_full, o_empty, o_overflow, o_busy, o_tx;
  logic [DL2:0]   o_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] rx[$];
  int         starts[$];
  logic [7:0] sent[$];

  bit         dec_act = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_b = 8'h00;

  uart_tx_buffered #(
    .TIMER_BITS(32), .CLOCKS_PER_BAUD(32'(CPB)), .DEPTH_LOG2(DL2)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_wr(i_wr), .i_data(i_data),
    .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
    .o_overflow(o_overflow), .o_busy(o_busy), .o_tx(o_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_rx(input int n, input int budget);
    int b = 0;
    while (rx.size() < n && b < budget) begin tick(); b++; end
    chk("rx_count", 32'(rx.size()), 32'(n));
  endtask

  // Line bit k of an 8N1 frame: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic fbit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return d[k-1];
  endfunction

  // Bit-centre sampling decoder on the serial line.
  always @(negedge clk) begin
    int k;
    if (i_reset) dec_act = 1'b0;
    else if (!dec_act) begin
      if (o_tx === 1'b0) begin dec_act = 1'b1; dec_cnt = 0; starts.push_back(cyc); end
    end else begin
      dec_cnt++;
      if (dec_cnt % CPB == CPB / 2) begin
        k = dec_cnt / CPB;
        if (k == 0) chk("start_bit", 32'(o_tx), 0);
        else if (k <= 8) dec_b[k-1] = o_tx;
        else begin
          chk("stop_bit", 32'(o_tx), 1);
          rx.push_back(dec_b);
          dec_act = 1'b0;
        end
      end
    end
  end

  initial begin
    int s, lows, n;
    logic [7:0] d;

    // Reset state
    i_reset = 1'b1; tick(); tick(); i_reset = 1'b0;
    chk("rst_tx", 32'(o_tx), 1);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_empty", 32'(o_empty), 1);
    chk("rst_full", 32'(o_full), 0);
    chk("rst_ovf", 32'(o_overflow), 0);

    // Single byte 0x55: latency and exact waveform
    rx.delete(); starts.delete();
    d = 8'h55;
    i_wr = 1'b1; i_data = d; tick(); i_wr = 1'b0;
    chk("w1_count", 32'(o_count), 1);
    tick(); s = cyc;
    chk("w1_busy", 32'(o_busy), 1);
    for (int t = 0; t < 10 * CPB; t++) begin
      chk($sformatf("w1_line_t%0d", t), 32'(o_tx), 32'(fbit(d, t / CPB)));
      tick();
    end
    chk("w1_done_busy", 32'(o_busy), 0);
    chk("w1_done_empty", 32'(o_empty), 1);
    chk("w1_done_tx", 32'(o_tx), 1);
    chk("w1_rx_n", 32'(rx.size()), 1);
    if (rx.size() > 0) chk("w1_rx", 32'(rx[0]), 32'h55);

    // Back-to-back pair 0xA5, 0x3C
    rx.delete(); starts.delete();
    i_wr = 1'b1; i_data = 8'hA5; tick();
    i_data = 8'h3C; tick(); i_wr = 1'b0; s = cyc;
    chk("b2b_count", 32'(o_count), 1);
    wait_cyc(s + 20 * CPB - 1);
    chk("b2b_busy_end", 32'(o_busy), 1);
    tick();
    chk("b2b_idle", 32'(o_busy), 0);
    chk("b2b_rx_n", 32'(rx.size()), 2);
    if (rx.size() >= 2) begin
      chk("b2b_rx0", 32'(rx[0]), 32'hA5);
      chk("b2b_rx1", 32'(rx[1]), 32'h3C);
    end
    chk("b2b_starts_n", 32'(starts.size()), 2);
    if (starts.size() >= 2) chk("b2b_gap", 32'(starts[1] - starts[0]), 32'(10 * CPB));

    // Overflow: 18 bytes, then a write on the pop edge while full
    rx.delete(); starts.delete();
    s = 0;
    for (int i = 0; i < 18; i++) begin
      i_wr = 1'b1; i_data = 8'(i); tick();
      if (i == 1) s = cyc;
    end
    i_wr = 1'b0;
    chk("ovf_count", 32'(o_count), 16);
    chk("ovf_full", 32'(o_full), 1);
    chk("ovf_flag", 32'(o_overflow), 1);
    chk("ovf_empty", 32'(o_empty), 0);
    wait_cyc(s + 10 * CPB - 1);
    chk("pop_pre_count", 32'(o_count), 16);
    i_wr = 1'b1; i_data = 8'hEE; tick(); i_wr = 1'b0;
    chk("pop_count", 32'(o_count), 15);
    chk("pop_full", 32'(o_full), 0);
    chk("pop_ovf", 32'(o_overflow), 1);
    wait_rx(17, 17 * 10 * CPB + 100);
    for (int i = 0; i < 17 && i < rx.size(); i++)
      chk($sformatf("ovf_rx%0d", i), 32'(rx[i]), 32'(i));
    repeat (2 * CPB) tick();
    chk("ovf_drain_empty", 32'(o_empty), 1);
    chk("ovf_drain_busy", 32'(o_busy), 0);
    chk("ovf_drain_count", 32'(o_count), 0);
    chk("ovf_sticky", 32'(o_overflow), 1);
    chk("ovf_rx_total", 32'(rx.size()), 17);

    // Reset mid-frame with a simultaneous write
    rx.delete(); starts.delete();
    s = 0;
    for (int i = 0; i < 3; i++) begin
      i_wr = 1'b1; i_data = 8'hC0 + 8'(i); tick();
      if (i == 1) s = cyc;
    end
    i_wr = 1'b0;
    wait_cyc(s + 3 * CPB);
    i_reset = 1'b1; i_wr = 1'b1; i_data = 8'h77; tick();
    i_reset = 1'b0; i_wr = 1'b0;
    chk("mid_rst_tx", 32'(o_tx), 1);
    chk("mid_rst_count", 32'(o_count), 0);
    chk("mid_rst_busy", 32'(o_busy), 0);
    chk("mid_rst_empty", 32'(o_empty), 1);
    chk("mid_rst_ovf", 32'(o_overflow), 0);
    lows = 0;
    repeat (30 * CPB) begin tick(); if (o_tx !== 1'b1) lows++; end
    chk("mid_rst_line_idle", 32'(lows), 0);
    chk("mid_rst_rx_n", 32'(rx.size()), 0);
    chk("mid_rst_busy_after", 32'(o_busy), 0);

    // Randomized paced stream of 40 bytes (pointers wrap twice)
    rx.delete(); starts.delete(); sent.delete();
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      sent.push_back(d);
      i_wr = 1'b1; i_data = d; tick(); i_wr = 1'b0;
      repeat ($urandom_range(11 * CPB, 15 * CPB)) tick();
    end
    wait_rx(40, 40 * 10 * CPB + 200);
    n = (rx.size() < 40) ? rx.size() : 40;
    for (int i = 0; i < n; i++)
      chk($sformatf("rnd_rx%0d", i), 32'(rx[i]), 32'(sent[i]));
    chk("rnd_ovf", 32'(o_overflow), 0);
    repeat (2 * CPB) tick();
    chk("rnd_empty", 32'(o_empty), 1);
    chk("rnd_busy", 32'(o_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
